// File: rtl/commit_unit.sv
`default_nettype none
// ============================================================================
// Module   : commit_unit
// Purpose  : ROB commit consumer: applies results to the ARF, releases
//            stores, counts retirements and stops on ECALL/EBREAK/illegal.
// Revision : 1.0
// ============================================================================
module commit_unit #(
    parameter int XLEN          = 32,
    parameter int NUM_ARCH_REGS = 32
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             commitment_valid_i,
    input  logic [31:0]                      inst_committed_i,
    input  logic [XLEN-1:0]                  pc_committed_i,
    input  logic [$clog2(NUM_ARCH_REGS)-1:0] prd_addr_committed_i,
    input  logic [XLEN-1:0]                  prd_value_committed_i,
    output logic                             arf_we_o,
    output logic [$clog2(NUM_ARCH_REGS)-1:0] arf_waddr_o,
    output logic [XLEN-1:0]                  arf_wdata_o,
    output logic                             store_release_o,
    output logic [XLEN-1:0]                  store_pc_o,
    output logic                             halt_o,
    output logic                             error_o,
    output logic [31:0]                      retired_cnt_o,
    output logic [XLEN-1:0]                  last_pc_o,
    input  logic [$clog2(NUM_ARCH_REGS)-1:0] dbg_raddr_i,
    output logic [XLEN-1:0]                  dbg_rdata_o
);

    localparam int AW = $clog2(NUM_ARCH_REGS);

    localparam logic [6:0]  c_OP_LUI    = 7'b0110111;
    localparam logic [6:0]  c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  c_OP_JAL    = 7'b1101111;
    localparam logic [6:0]  c_OP_JALR   = 7'b1100111;
    localparam logic [6:0]  c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  c_OP_OPIMM  = 7'b0010011;
    localparam logic [6:0]  c_OP_OP     = 7'b0110011;
    localparam logic [6:0]  c_OP_STORE  = 7'b0100011;
    localparam logic [6:0]  c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  c_OP_SYSTEM = 7'b1110011;
    localparam logic [31:0] c_ECALL     = 32'h0000_0073;
    localparam logic [31:0] c_EBREAK    = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    state_t            r_state_q,       w_state_d;
    logic [XLEN-1:0]   r_arf_q [NUM_ARCH_REGS];
    logic [XLEN-1:0]   w_arf_d [NUM_ARCH_REGS];
    logic              r_we_q,          w_we_d;
    logic [AW-1:0]     r_waddr_q,       w_waddr_d;
    logic [XLEN-1:0]   r_wdata_q,       w_wdata_d;
    logic              r_rel_q,         w_rel_d;
    logic [XLEN-1:0]   r_store_pc_q,    w_store_pc_d;
    logic [31:0]       r_retired_cnt_q, w_retired_cnt_d;
    logic [XLEN-1:0]   r_last_pc_q,     w_last_pc_d;

    logic       w_accept;
    logic       w_writes_rd;
    logic       w_legal;
    logic       w_is_store;
    logic       w_is_stop;
    logic [6:0] w_opcode;

    assign w_opcode = inst_committed_i[6:0];
    assign w_accept = commitment_valid_i && (r_state_q == ST_RUN);

    always_comb begin
        w_writes_rd = 1'b0;
        w_legal     = 1'b1;
        case (w_opcode)
            c_OP_LUI, c_OP_AUIPC, c_OP_JAL, c_OP_JALR,
            c_OP_LOAD, c_OP_OPIMM, c_OP_OP:         w_writes_rd = 1'b1;
            c_OP_STORE, c_OP_BRANCH, c_OP_SYSTEM:   w_writes_rd = 1'b0;
            default:                                w_legal     = 1'b0;
        endcase
    end

    assign w_is_store = (w_opcode == c_OP_STORE);
    assign w_is_stop  = (inst_committed_i == c_ECALL) || (inst_committed_i == c_EBREAK);

    always_comb begin
        w_state_d       = r_state_q;
        w_arf_d         = r_arf_q;
        w_we_d          = 1'b0;
        w_waddr_d       = r_waddr_q;
        w_wdata_d       = r_wdata_q;
        w_rel_d         = 1'b0;
        w_store_pc_d    = r_store_pc_q;
        w_retired_cnt_d = r_retired_cnt_q;
        w_last_pc_d     = r_last_pc_q;
        if (w_accept) begin
            if (!w_legal) begin
                // Illegal instructions never retire: counter and PC stay put.
                w_state_d = ST_ERROR;
            end else begin
                w_retired_cnt_d = r_retired_cnt_q + 32'd1;
                w_last_pc_d     = pc_committed_i;
                if (w_writes_rd && (prd_addr_committed_i != '0)) begin
                    w_arf_d[prd_addr_committed_i] = prd_value_committed_i;
                    w_we_d    = 1'b1;
                    w_waddr_d = prd_addr_committed_i;
                    w_wdata_d = prd_value_committed_i;
                end
                if (w_is_store) begin
                    w_rel_d      = 1'b1;
                    w_store_pc_d = pc_committed_i;
                end
                if (w_is_stop) begin
                    w_state_d = ST_HALT;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state_q       <= ST_RUN;
            r_arf_q         <= '{default: '0};
            r_we_q          <= 1'b0;
            r_waddr_q       <= '0;
            r_wdata_q       <= '0;
            r_rel_q         <= 1'b0;
            r_store_pc_q    <= '0;
            r_retired_cnt_q <= '0;
            r_last_pc_q     <= '0;
        end else begin
            r_state_q       <= w_state_d;
            r_arf_q         <= w_arf_d;
            r_we_q          <= w_we_d;
            r_waddr_q       <= w_waddr_d;
            r_wdata_q       <= w_wdata_d;
            r_rel_q         <= w_rel_d;
            r_store_pc_q    <= w_store_pc_d;
            r_retired_cnt_q <= w_retired_cnt_d;
            r_last_pc_q     <= w_last_pc_d;
        end
    end

    assign arf_we_o        = r_we_q;
    assign arf_waddr_o     = r_waddr_q;
    assign arf_wdata_o     = r_wdata_q;
    assign store_release_o = r_rel_q;
    assign store_pc_o      = r_store_pc_q;
    assign halt_o          = (r_state_q == ST_HALT);
    assign error_o         = (r_state_q == ST_ERROR);
    assign retired_cnt_o   = r_retired_cnt_q;
    assign last_pc_o       = r_last_pc_q;
    // x0 is masked here as well so the read never depends on entry 0 contents.
    assign dbg_rdata_o     = (dbg_raddr_i == '0) ? '0 : r_arf_q[dbg_raddr_i];

endmodule
`default_nettype wire

// File: tb/tb_commit_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_commit_unit
// Purpose  : Directed self-checking bench for commit_unit with a retirement
//            model compared every cycle plus hand-computed literal checks.
// Revision : 1.0
// ============================================================================
module tb_commit_unit;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        commitment_valid_i = 1'b0;
    logic [31:0] inst_committed_i = '0;
    logic [31:0] pc_committed_i = '0;
    logic [4:0]  prd_addr_committed_i = '0;
    logic [31:0] prd_value_committed_i = '0;
    logic [4:0]  dbg_raddr_i = '0;
    logic        arf_we_o;
    logic [4:0]  arf_waddr_o;
    logic [31:0] arf_wdata_o;
    logic        store_release_o;
    logic [31:0] store_pc_o;
    logic        halt_o;
    logic        error_o;
    logic [31:0] retired_cnt_o;
    logic [31:0] last_pc_o;
    logic [31:0] dbg_rdata_o;

    always #5 clk = ~clk;

    commit_unit #(.XLEN(32), .NUM_ARCH_REGS(32)) dut (
        .clk_i                 (clk),
        .reset_i               (reset_i),
        .commitment_valid_i    (commitment_valid_i),
        .inst_committed_i      (inst_committed_i),
        .pc_committed_i        (pc_committed_i),
        .prd_addr_committed_i  (prd_addr_committed_i),
        .prd_value_committed_i (prd_value_committed_i),
        .arf_we_o              (arf_we_o),
        .arf_waddr_o           (arf_waddr_o),
        .arf_wdata_o           (arf_wdata_o),
        .store_release_o       (store_release_o),
        .store_pc_o            (store_pc_o),
        .halt_o                (halt_o),
        .error_o               (error_o),
        .retired_cnt_o         (retired_cnt_o),
        .last_pc_o             (last_pc_o),
        .dbg_raddr_i           (dbg_raddr_i),
        .dbg_rdata_o           (dbg_rdata_o)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    // Architectural view of what the unit should present.
    logic [31:0] m_arf [32];
    logic [31:0] m_cnt, m_last_pc, m_spc, m_wdata;
    logic [4:0]  m_waddr;
    bit          m_we, m_rel, m_halt, m_err;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    function automatic bit writes_rd(logic [6:0] op);
        return op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                          7'b0000011, 7'b0010011, 7'b0110011};
    endfunction

    function automatic bit is_legal(logic [6:0] op);
        return writes_rd(op) || (op inside {7'b0100011, 7'b1100011, 7'b1110011});
    endfunction

    task automatic model_step();
        m_we  = 1'b0;
        m_rel = 1'b0;
        if (reset_i) begin
            foreach (m_arf[i]) m_arf[i] = '0;
            m_cnt = '0; m_last_pc = '0; m_spc = '0; m_wdata = '0; m_waddr = '0;
            m_halt = 1'b0; m_err = 1'b0;
        end else if (commitment_valid_i && !m_halt && !m_err) begin
            if (!is_legal(inst_committed_i[6:0])) begin
                m_err = 1'b1;
            end else begin
                m_cnt     = m_cnt + 1;
                m_last_pc = pc_committed_i;
                if (writes_rd(inst_committed_i[6:0]) && prd_addr_committed_i != 0) begin
                    m_arf[prd_addr_committed_i] = prd_value_committed_i;
                    m_we = 1'b1; m_waddr = prd_addr_committed_i; m_wdata = prd_value_committed_i;
                end
                if (inst_committed_i[6:0] == 7'b0100011) begin
                    m_rel = 1'b1; m_spc = pc_committed_i;
                end
                if (inst_committed_i == 32'h0000_0073 || inst_committed_i == 32'h0010_0073)
                    m_halt = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("halt_o", {31'd0, halt_o}, {31'd0, m_halt});
            chk("error_o", {31'd0, error_o}, {31'd0, m_err});
            chk("arf_we_o", {31'd0, arf_we_o}, {31'd0, m_we});
            chk("arf_waddr_o", {27'd0, arf_waddr_o}, {27'd0, m_waddr});
            chk("arf_wdata_o", arf_wdata_o, m_wdata);
            chk("store_release_o", {31'd0, store_release_o}, {31'd0, m_rel});
            chk("store_pc_o", store_pc_o, m_spc);
            chk("retired_cnt_o", retired_cnt_o, m_cnt);
            chk("last_pc_o", last_pc_o, m_last_pc);
            chk("dbg_rdata_o", dbg_rdata_o, (dbg_raddr_i == 0) ? 32'd0 : m_arf[dbg_raddr_i]);
        end
    end

    task automatic cyc(input bit rst, input bit v, input logic [31:0] inst,
                       input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] val);
        reset_i = rst; commitment_valid_i = v; inst_committed_i = inst;
        pc_committed_i = pc; prd_addr_committed_i = rd; prd_value_committed_i = val;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic dbg_lit(string name, input logic [4:0] a, input logic [31:0] exp);
        dbg_raddr_i = a;
        #1;
        chk(name, dbg_rdata_o, exp);
    endtask

    initial begin
        foreach (m_arf[i]) m_arf[i] = '0;
        #1;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        chk("lit_rst_cnt", retired_cnt_o, 32'd0);
        chk("lit_rst_halt", {31'd0, halt_o}, 32'd0);

        // ADDI x5 = 0xA
        cyc(0, 1, 32'h00A0_0293, 32'h0000_1000, 5'd5, 32'h0000_000A);
        chk("lit_addi_we", {31'd0, arf_we_o}, 32'd1);
        chk("lit_addi_waddr", {27'd0, arf_waddr_o}, 32'd5);
        chk("lit_addi_wdata", arf_wdata_o, 32'hA);
        chk("lit_addi_cnt", retired_cnt_o, 32'd1);
        chk("lit_addi_pc", last_pc_o, 32'h1000);
        dbg_lit("lit_dbg_x5", 5'd5, 32'hA);

        // OP with rd = x0 is counted but never written
        cyc(0, 1, 32'h0000_0033, 32'h0000_1004, 5'd0, 32'hDEAD_BEEF);
        chk("lit_x0_we", {31'd0, arf_we_o}, 32'd0);
        chk("lit_x0_cnt", retired_cnt_o, 32'd2);
        dbg_lit("lit_dbg_x0", 5'd0, 32'd0);

        // Back-to-back x3 writes with a store in between
        dbg_raddr_i = 5'd3;
        cyc(0, 1, 32'h0000_01B3, 32'h0000_00F8, 5'd3, 32'd1);
        cyc(0, 1, 32'h0051_2023, 32'h0000_0100, 5'd0, 32'h1234_5678);
        chk("lit_st_rel", {31'd0, store_release_o}, 32'd1);
        chk("lit_st_pc", store_pc_o, 32'h100);
        chk("lit_st_we", {31'd0, arf_we_o}, 32'd0);
        cyc(0, 1, 32'h0000_01B3, 32'h0000_0104, 5'd3, 32'd2);
        chk("lit_st_pulse_end", {31'd0, store_release_o}, 32'd0);
        chk("lit_st_pc_hold", store_pc_o, 32'h100);
        cyc(0, 1, 32'h0000_01B3, 32'h0000_0108, 5'd3, 32'd3);
        dbg_lit("lit_dbg_x3", 5'd3, 32'd3);
        chk("lit_b2b_cnt", retired_cnt_o, 32'd6);

        // CSR read and branch retire without writes; idle cycle in between
        cyc(0, 1, 32'h3420_2573, 32'h0000_010C, 5'd10, 32'h5555_5555);
        cyc(0, 0, 32'h0070_0313, 32'h0000_0110, 5'd6, 32'h9);
        cyc(0, 1, 32'h0000_0063, 32'h0000_0114, 5'd0, 32'h0);
        dbg_lit("lit_dbg_x10", 5'd10, 32'd0);

        // EBREAK then ADDI x6 = 7 (dropped)
        cyc(0, 1, 32'h0010_0073, 32'h0000_0200, 5'd0, 32'h0);
        chk("lit_halt", {31'd0, halt_o}, 32'd1);
        chk("lit_halt_cnt", retired_cnt_o, 32'd9);
        chk("lit_halt_pc", last_pc_o, 32'h200);
        cyc(0, 1, 32'h0070_0313, 32'h0000_0204, 5'd6, 32'd7);
        dbg_lit("lit_dbg_x6", 5'd6, 32'd0);
        chk("lit_halt_frozen", retired_cnt_o, 32'd9);

        // Fresh run: write x5, then an illegal word
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'h0550_0293, 32'h0000_02FC, 5'd5, 32'h55);
        cyc(0, 1, 32'hFFFF_FFFF, 32'h0000_0300, 5'd7, 32'h77);
        chk("lit_err", {31'd0, error_o}, 32'd1);
        chk("lit_err_cnt", retired_cnt_o, 32'd1);
        chk("lit_err_pc", last_pc_o, 32'h2FC);
        cyc(0, 1, 32'h0070_0313, 32'h0000_0304, 5'd6, 32'd7);
        dbg_lit("lit_err_x6", 5'd6, 32'd0);
        // Reset wins over a concurrent commit
        cyc(1, 1, 32'h0070_0393, 32'h0000_0308, 5'd7, 32'd7);
        chk("lit_rst2_err", {31'd0, error_o}, 32'd0);
        chk("lit_rst2_cnt", retired_cnt_o, 32'd0);
        chk("lit_rst2_pc", last_pc_o, 32'd0);
        dbg_lit("lit_rst2_x5", 5'd5, 32'd0);
        dbg_lit("lit_rst2_x7", 5'd7, 32'd0);

        // Counter wrap
        cyc(0, 1, 32'h0000_00EF, 32'h0000_0400, 5'd1, 32'h0000_0404);
        force dut.r_retired_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired_cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        cyc(0, 0, 0, 0, 0, 0);
        chk("lit_pre_wrap", retired_cnt_o, 32'hFFFF_FFFF);
        cyc(0, 1, 32'h0070_0313, 32'h0000_0408, 5'd6, 32'd7);
        chk("lit_wrap", retired_cnt_o, 32'd0);
        dbg_lit("lit_wrap_x6", 5'd6, 32'd7);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
